// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage streaming bitwise logic unit with valid/ready
// handshakes, result flags and a wrapping completed-operation counter.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_ANDN = 3'b111;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] s2_next;

    // Advance conditions; in_ready depends only on out_ready and stage valids
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Bitwise operation evaluated from the S1 registers
    always_comb begin
        s2_next = '0;
        case (s1_op)
            OP_AND:  s2_next = s1_a & s1_b;
            OP_OR:   s2_next = s1_a | s1_b;
            OP_XOR:  s2_next = s1_a ^ s1_b;
            OP_NOR:  s2_next = ~(s1_a | s1_b);
            OP_NAND: s2_next = ~(s1_a & s1_b);
            OP_XNOR: s2_next = ~(s1_a ^ s1_b);
            OP_NOTA: s2_next = ~s1_a;
            OP_ANDN: s2_next = s1_a & ~s1_b;
            default: s2_next = '0;
        endcase
    end

    // Stage 1: capture operands on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    // Stage 2: register result and flags; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
            parity    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= s2_next;
                zero   <= ~|s2_next;
                ones   <= &s2_next;
                parity <= ^s2_next;
            end
        end
    end

    // Count consumed results, wrapping at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [2:0] op = '0;

    logic       in_ready, out_valid, zero, ones, parity;
    logic [3:0] result;
    logic [7:0] op_count;

    logic       in_ready2, out_valid2, zero2, ones2, parity2;
    logic [3:0] result2;
    logic [1:0] op_count2;

    int n_tests = 0;
    int n_fail  = 0;

    logic_unit_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ones(ones), .parity(parity),
        .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .zero(zero2), .ones(ones2), .parity(parity2),
        .op_count(op_count2)
    );

    always #5 clk = ~clk;

    // Reference for the full-pipe scenario
    function automatic logic [3:0] model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        case (o)
            3'b000: return x & y;
            3'b001: return x | y;
            3'b010: return x ^ y;
            3'b011: return ~(x | y);
            3'b100: return ~(x & y);
            3'b101: return ~(x ^ y);
            3'b110: return ~x;
            default: return x & ~y;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        in_valid = v;
        op = o;
        a = x;
        b = y;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if ({result, zero, ones, parity} !== 7'b0) begin n_fail++; $display("FAIL reset_fields got %b want 0000000", {result, zero, ones, parity}); end
        n_tests++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        set_in(1'b1, 3'b011, 4'b0110, 4'b1001);
        step();
        set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid got %b want 0", out_valid); end
        step();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", out_valid); end
        n_tests++; if ({result, zero, ones, parity} !== {4'b0000, 3'b100}) begin n_fail++; $display("FAIL lat_nor_result got %b want 0000100", {result, zero, ones, parity}); end
        step();
        n_tests++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL lat_op_count got %0d want 1", op_count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain got %b want 0", out_valid); end
    endtask

    task automatic test_ops();
        out_ready = 1'b1;
        set_in(1'b1, 3'b011, 4'b0000, 4'b0000);
        step();
        set_in(1'b1, 3'b010, 4'b1100, 4'b1010);
        step();
        n_tests++; if ({out_valid, result, zero, ones, parity} !== {1'b1, 4'b1111, 3'b010}) begin n_fail++; $display("FAIL ops_nor_zero got %b want 11111010", {out_valid, result, zero, ones, parity}); end
        set_in(1'b1, 3'b111, 4'b1111, 4'b0101);
        step();
        set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
        n_tests++; if ({out_valid, result, zero, ones, parity} !== {1'b1, 4'b0110, 3'b000}) begin n_fail++; $display("FAIL ops_xor got %b want 10110000", {out_valid, result, zero, ones, parity}); end
        step();
        n_tests++; if ({out_valid, result, zero, ones, parity} !== {1'b1, 4'b1010, 3'b000}) begin n_fail++; $display("FAIL ops_andn got %b want 11010000", {out_valid, result, zero, ones, parity}); end
        step();
        n_tests++; if (op_count !== 8'd4) begin n_fail++; $display("FAIL ops_op_count got %0d want 4", op_count); end
    endtask

    task automatic test_backpressure();
        test_reset();
        out_ready = 1'b0;
        set_in(1'b1, 3'b000, 4'b1111, 4'b0011);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        step();
        set_in(1'b1, 3'b001, 4'b0001, 4'b0010);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready2 got %b want 1", in_ready); end
        step();
        set_in(1'b1, 3'b010, 4'b1111, 4'b0000);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b want 0", in_ready); end
        step();
        // operands wiggled while blocked must be ignored
        set_in(1'b1, 3'b110, 4'b0101, 4'b0101);
        step();
        set_in(1'b1, 3'b010, 4'b1111, 4'b0000);
        n_tests++; if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 4'b0011}) begin n_fail++; $display("FAIL bp_hold got %b want 010011", {in_ready, out_valid, result}); end
        n_tests++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL bp_no_count got %0d want 0", op_count); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        step();
        set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
        n_tests++; if ({out_valid, result} !== {1'b1, 4'b0011}) begin n_fail++; $display("FAIL bp_second got %b want 10011", {out_valid, result}); end
        step();
        n_tests++; if ({out_valid, result} !== {1'b1, 4'b1111}) begin n_fail++; $display("FAIL bp_third got %b want 11111", {out_valid, result}); end
        step();
        n_tests++; if ({out_valid, op_count} !== {1'b0, 8'd3}) begin n_fail++; $display("FAIL bp_drain got %b want 000000011", {out_valid, op_count}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_q[10];
        test_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                set_in(1'b1, 3'(k), 4'(k * 3), 4'(k + 5));
                exp_q[k] = model(3'(k), 4'(k * 3), 4'(k + 5));
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", k, in_ready); end
            end else begin
                set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
            end
            step();
            if (k >= 1 && k <= 10) begin
                n_tests++;
                if ({out_valid, result, parity} !== {1'b1, exp_q[k-1], ^exp_q[k-1]}) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d] got %b want %b", k - 1, {out_valid, result, parity}, {1'b1, exp_q[k-1], ^exp_q[k-1]});
                end
            end
        end
        n_tests++; if ({out_valid, op_count} !== {1'b0, 8'd10}) begin n_fail++; $display("FAIL b2b_op_count got %b want 000001010", {out_valid, op_count}); end
    endtask

    task automatic test_reset_mid_op();
        out_ready = 1'b0;
        set_in(1'b1, 3'b001, 4'b1010, 4'b0101);
        step();
        set_in(1'b1, 3'b100, 4'b0011, 4'b0001);
        step();
        set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
        n_tests++; if ({out_valid, result, op_count} !== {1'b1, 4'b1111, 8'd10}) begin n_fail++; $display("FAIL mid_inflight got %b want 1111100001010", {out_valid, result, op_count}); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({out_valid, result, zero, ones, parity, op_count} !== 16'd0) begin n_fail++; $display("FAIL mid_async_clear got %b want 0", {out_valid, result, zero, ones, parity, op_count}); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL mid_stale[%0d] got %b want 10", k, {in_ready, out_valid}); end
        end
    endtask

    task automatic test_count_wrap();
        logic [1:0] exp_cnt[5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        test_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) set_in(1'b1, 3'b010, 4'(k), 4'b0001);
            else       set_in(1'b0, 3'b000, 4'b0000, 4'b0000);
            step();
            if (k >= 2) begin
                n_tests++;
                if (op_count2 !== exp_cnt[k-2]) begin
                    n_fail++;
                    $display("FAIL wrap_count[%0d] got %0d want %0d", k - 2, op_count2, exp_cnt[k-2]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
